// File: rtl/ht_pkg.sv
// ht_pkg: opcode and result constants, FSM states and tuple field offsets shared by the
// hash-table pipeline stages.
package ht_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_B1, S_WAIT_B2, S_OUTPUT} state_t;

    localparam int OP_WIDTH = 4;
    localparam logic [OP_WIDTH-1:0] OP_SKIP_A = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_SKIP_B = 4'd7;

    localparam logic [1:0] RES_FULL = 2'd0;
    localparam logic [1:0] RES_HIT1 = 2'd1;
    localparam logic [1:0] RES_HIT2 = 2'd2;
    localparam logic [1:0] RES_FREE = 2'd3;

    function automatic int op_lsb(input int key_width, input int meta_width);
        return key_width + meta_width - 8;
    endfunction

    function automatic int user_lsb(input int key_width, input int meta_width);
        return key_width + meta_width;
    endfunction

    function automatic int hash_lsb(input int key_width, input int meta_width, input int user_bits);
        return key_width + meta_width + user_bits;
    endfunction

    // Skipped tuples never had a bucket read issued by the read stage.
    function automatic logic is_skip(input logic [OP_WIDTH-1:0] op);
        return op == OP_SKIP_A || op == OP_SKIP_B;
    endfunction

endpackage

// File: rtl/ht_bucket_eval.sv
// ht_bucket_eval: classifies one bucket word against the tuple key (hit, free slot, stored pointer).
module ht_bucket_eval #(
    parameter int KEY_WIDTH     = 128,
    parameter int MEMDATA_WIDTH = 512,
    parameter int VALPTR_WIDTH  = 32
) (
    input  logic [MEMDATA_WIDTH-1:0] word,
    input  logic [KEY_WIDTH-1:0]     key,
    output logic                     hit,
    output logic                     free,
    output logic [VALPTR_WIDTH-1:0]  valptr
);

    logic unused_bits;

    assign hit         = word[MEMDATA_WIDTH-1] && word[KEY_WIDTH-1:0] == key;
    assign free        = !word[MEMDATA_WIDTH-1];
    assign valptr      = word[KEY_WIDTH +: VALPTR_WIDTH];
    assign unused_bits = ^word[MEMDATA_WIDTH-2:KEY_WIDTH+VALPTR_WIDTH];

endmodule

// File: rtl/ht_bucket_compare.sv
// ht_bucket_compare: compares both bucket words against the tuple key and emits {code, valptr, addr, tuple}.
// Define HT_CMP_STATS_EN to add the stat_hits / stat_misses counters.
module ht_bucket_compare
    import ht_pkg::*;
#(
    parameter int KEY_WIDTH      = 128,
    parameter int META_WIDTH     = 96,
    parameter int HASHADDR_WIDTH = 64,
    parameter int USER_BITS      = 3,
    parameter int MEMADDR_WIDTH  = 21,
    parameter int MEMDATA_WIDTH  = 512,
    parameter int VALPTR_WIDTH   = 32,
    localparam int TW = KEY_WIDTH + META_WIDTH + USER_BITS + HASHADDR_WIDTH,
    localparam int OW = TW + MEMADDR_WIDTH + VALPTR_WIDTH + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TW-1:0]            input_data,
    input  logic                     input_valid,
    output logic                     input_ready,
    input  logic [MEMDATA_WIDTH-1:0] rddata_data,
    input  logic                     rddata_valid,
    output logic                     rddata_ready,
    output logic [OW-1:0]            output_data,
    output logic                     output_valid,
    input  logic                     output_ready
`ifdef HT_CMP_STATS_EN
    ,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses
`endif
);

    localparam int AW       = MEMADDR_WIDTH - USER_BITS;
    localparam int HH       = HASHADDR_WIDTH / 2;
    localparam int OP_LSB   = op_lsb(KEY_WIDTH, META_WIDTH);
    localparam int USER_LSB = user_lsb(KEY_WIDTH, META_WIDTH);
    localparam int HASH_LSB = hash_lsb(KEY_WIDTH, META_WIDTH, USER_BITS);

    state_t                     state, next_state;
    logic [TW-1:0]              tuple;
    logic [HASHADDR_WIDTH-1:0]  hash;
    logic [USER_BITS-1:0]       user;
    logic [MEMADDR_WIDTH-1:0]   addr1, addr2, addr;
    logic                       hit, free, hit1, free1;
    logic [VALPTR_WIDTH-1:0]    valptr, valptr1, vp;
    logic [1:0]                 code;
    logic                       accept, skip, b1_take, b2_take, unused_hash;

    ht_bucket_eval #(
        .KEY_WIDTH    (KEY_WIDTH),
        .MEMDATA_WIDTH(MEMDATA_WIDTH),
        .VALPTR_WIDTH (VALPTR_WIDTH)
    ) u_eval (
        .word  (rddata_data),
        .key   (tuple[KEY_WIDTH-1:0]),
        .hit   (hit),
        .free  (free),
        .valptr(valptr)
    );

    assign hash        = tuple[HASH_LSB +: HASHADDR_WIDTH];
    assign user        = tuple[USER_LSB +: USER_BITS];
    assign addr1       = {user, hash[AW-1:0]};
    assign addr2       = {user, hash[HH +: AW]};
    assign unused_hash = ^{hash[HH-1:AW], hash[HASHADDR_WIDTH-1:HH+AW]};
    assign accept      = state == S_IDLE && input_ready && input_valid;
    assign skip        = is_skip(input_data[OP_LSB +: OP_WIDTH]);
    assign b1_take     = state == S_WAIT_B1 && rddata_valid;
    assign b2_take     = state == S_WAIT_B2 && rddata_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    next_state = accept ? (skip ? S_OUTPUT : S_WAIT_B1) : S_IDLE;
            S_WAIT_B1: next_state = rddata_valid ? S_WAIT_B2 : S_WAIT_B1;
            S_WAIT_B2: next_state = rddata_valid ? S_OUTPUT : S_WAIT_B2;
            S_OUTPUT:  next_state = output_ready ? S_IDLE : S_OUTPUT;
        endcase
    end

    always_comb begin
        rddata_ready = state == S_WAIT_B1 || state == S_WAIT_B2;
    end

    // Bucket 2 is evaluated on the arriving word and merged with the stored bucket 1 result.
    always_comb begin
        code = hit1 ? RES_HIT1 : hit ? RES_HIT2 : (free1 || free) ? RES_FREE : RES_FULL;
        addr = (!hit1 && (hit || (!free1 && free))) ? addr2 : addr1;
        vp   = hit1 ? valptr1 : hit ? valptr : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_ready  <= 1'b0;
            output_valid <= 1'b0;
            output_data  <= '0;
            tuple        <= '0;
            hit1         <= 1'b0;
            free1        <= 1'b0;
            valptr1      <= '0;
        end else begin
            input_ready  <= input_valid && !input_ready && next_state == S_IDLE;
            output_valid <= next_state == S_OUTPUT;
            if (accept) tuple <= input_data;
            if (accept && skip) output_data <= {RES_FULL, {VALPTR_WIDTH{1'b0}}, {MEMADDR_WIDTH{1'b0}}, input_data};
            if (b1_take) {hit1, free1, valptr1} <= {hit, free, valptr};
            if (b2_take) output_data <= {code, vp, addr, tuple};
        end
    end

`ifdef HT_CMP_STATS_EN
    logic [1:0] out_code;
    assign out_code = output_data[OW-1 -: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (output_valid && output_ready) begin
            if (out_code == RES_HIT1 || out_code == RES_HIT2) stat_hits <= stat_hits + 32'd1;
            else if (!is_skip(output_data[OP_LSB +: OP_WIDTH])) stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ht_bucket_compare.sv
// tb_ht_bucket_compare: table-driven bench for ht_bucket_compare plus backpressure and reset sequences.
module tb_ht_bucket_compare;

    localparam int TW = 291;
    localparam int OW = 346;
    localparam logic [127:0] K1  = 128'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789;
    localparam logic [127:0] K1X = 128'hABCD_EF01_2345_6789_ABCD_EF01_2345_6788;
    localparam logic [127:0] K3  = 128'h2BCD_EF01_2345_6789_ABCD_EF01_2345_6789;
    localparam logic [127:0] K2  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam int NV = 10;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   op;
        logic [2:0]   user;
        logic [31:0]  hlo;
        logic [31:0]  hhi;
        logic         o1;
        logic [127:0] k1;
        logic [31:0]  v1;
        logic         o2;
        logic [127:0] k2;
        logic [31:0]  v2;
        logic [1:0]   code;
        logic [20:0]  addr;
        logic [31:0]  vp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] input_data;
    logic          input_valid;
    logic          input_ready;
    logic [511:0]  rddata_data;
    logic          rddata_valid;
    logic          rddata_ready;
    logic [OW-1:0] output_data;
    logic          output_valid;
    logic          output_ready;
`ifdef HT_CMP_STATS_EN
    logic [31:0]   stat_hits, stat_misses;
    int            exp_hits = 0, exp_misses = 0;
`endif

    vec_t vecs[NV];
    int   checks = 0;
    int   errors = 0;

    ht_bucket_compare dut (
        .clk(clk), .rst(rst),
        .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
        .rddata_data(rddata_data), .rddata_valid(rddata_valid), .rddata_ready(rddata_ready),
        .output_data(output_data), .output_valid(output_valid), .output_ready(output_ready)
`ifdef HT_CMP_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] mk_tuple(input vec_t v);
        logic [TW-1:0] t;
        t = '0;
        t[127:0]   = v.key;
        t[215:128] = {22{4'hA}};
        t[219:216] = v.op;
        t[223:220] = 4'hC;
        t[226:224] = v.user;
        t[258:227] = v.hlo;
        t[290:259] = v.hhi;
        return t;
    endfunction

    function automatic logic [511:0] mk_word(input logic o, input logic [127:0] k, input logic [31:0] vp);
        logic [511:0] w;
        w = '0;
        w[127:0]    = k;
        w[159:128]  = vp;
        w[331:300]  = 32'hDEAD_BEEF;
        w[511]      = o;
        return w;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input int i);
        int n = 0;
        input_data  = mk_tuple(vecs[i]);
        input_valid = 1'b1;
        while (!input_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept[%0d]", i), input_ready, 1);
    endtask

    // Starts at the negedge of the input_ready pulse cycle; nxt >= 0 keeps input_valid high with that vector.
    task automatic complete(input int i, input bit rdy, input int nxt);
        vec_t v = vecs[i];
        logic sk = v.op == 4'd0 || v.op == 4'd7;
        chk($sformatf("rdready_T[%0d]", i), rddata_ready, 0);
        output_ready = rdy;
        if (!sk) begin
            rddata_data  = mk_word(v.o1, v.k1, v.v1);
            rddata_valid = 1'b1;
        end
        @(negedge clk);
        if (nxt >= 0) input_data = mk_tuple(vecs[nxt]);
        else input_valid = 1'b0;
        if (!sk) begin
            chk($sformatf("rdready_T1[%0d]", i), rddata_ready, 1);
            chk($sformatf("early_valid_T1[%0d]", i), output_valid, 0);
            @(negedge clk);
            rddata_data = mk_word(v.o2, v.k2, v.v2);
            chk($sformatf("rdready_T2[%0d]", i), rddata_ready, 1);
            chk($sformatf("early_valid_T2[%0d]", i), output_valid, 0);
            @(negedge clk);
            rddata_valid = 1'b0;
        end
        chk($sformatf("rdready_out[%0d]", i), rddata_ready, 0);
        chk($sformatf("out_valid[%0d]", i), output_valid, 1);
        chk($sformatf("code[%0d]", i), output_data[345:344], v.code);
        chk($sformatf("valptr[%0d]", i), output_data[343:312], v.vp);
        chk($sformatf("addr[%0d]", i), output_data[311:291], v.addr);
        chk($sformatf("tuple[%0d]", i), output_data[290:0], mk_tuple(v));
        if (rdy) begin
`ifdef HT_CMP_STATS_EN
            if (v.code == 2'd1 || v.code == 2'd2) exp_hits++;
            else if (!sk) exp_misses++;
`endif
            @(negedge clk);
            chk($sformatf("out_clear[%0d]", i), output_valid, 0);
            chk($sformatf("next_accept[%0d]", i), input_ready, nxt >= 0);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_input_ready"}, input_ready, 0);
        chk({tag, "_rddata_ready"}, rddata_ready, 0);
        chk({tag, "_output_valid"}, output_valid, 0);
        chk({tag, "_output_data"}, output_data, 0);
    endtask

    initial begin
        logic [OW-1:0] held;
        //          key  op     user  hlo            hhi            o1    k1   v1        o2    k2   v2        code  addr        vp
        vecs[0] = '{K1, 4'h1, 3'd3, 32'hFFF1_2345, 32'hABCE_6789, 1'b1, K1,  32'h10, 1'b1, K1,  32'h99, 2'd1, 21'h0D2345, 32'h10};
        vecs[1] = '{K1, 4'h2, 3'd3, 32'hFFF1_2345, 32'hABCE_6789, 1'b1, K1X, 32'h10, 1'b1, K1,  32'h22, 2'd2, 21'h0E6789, 32'h22};
        vecs[2] = '{K1, 4'h3, 3'd3, 32'hFFF1_2345, 32'hABCE_6789, 1'b0, K2,  32'h55, 1'b1, K2,  32'h66, 2'd3, 21'h0D2345, 32'h0};
        vecs[3] = '{K1, 4'h1, 3'd5, 32'h0000_0001, 32'h0003_FFFF, 1'b1, K3,  32'h44, 1'b0, K1,  32'h77, 2'd3, 21'h17FFFF, 32'h0};
        vecs[4] = '{K1, 4'h8, 3'd5, 32'h0000_0001, 32'h0003_FFFF, 1'b1, K3,  32'h44, 1'b1, K1X, 32'h88, 2'd0, 21'h140001, 32'h0};
        vecs[5] = '{K1, 4'h7, 3'd5, 32'h0000_0001, 32'h0003_FFFF, 1'b1, K1,  32'h44, 1'b1, K1,  32'h88, 2'd0, 21'h000000, 32'h0};
        vecs[6] = '{K2, 4'h2, 3'd0, 32'h0004_0000, 32'hFFFF_FFFF, 1'b0, K2,  32'h11, 1'b1, K2,  32'h33, 2'd2, 21'h03FFFF, 32'h33};
        vecs[7] = '{K2, 4'h3, 3'd0, 32'h0004_0000, 32'hFFFF_FFFF, 1'b0, '0,  32'h0,  1'b0, '0,  32'h0,  2'd3, 21'h000000, 32'h0};
        vecs[8] = '{K2, 4'h0, 3'd7, 32'h0000_0000, 32'h0000_0001, 1'b1, K2,  32'h11, 1'b1, K2,  32'h33, 2'd0, 21'h000000, 32'h0};
        vecs[9] = '{K1, 4'hF, 3'd7, 32'h0000_0000, 32'h0000_0001, 1'b1, K1,  32'hFFFF_FFFF, 1'b0, '0, 32'h0, 2'd1, 21'h1C0000, 32'hFFFF_FFFF};

        rst = 1'b1;
        input_data = '0;
        input_valid = 1'b0;
        rddata_data = '0;
        rddata_valid = 1'b0;
        output_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
`ifdef HT_CMP_STATS_EN
        chk("reset_stat_hits", stat_hits, 0);
        chk("reset_stat_misses", stat_misses, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back table run: each response accepted immediately, next tuple already offered.
        accept(0);
        for (int i = 0; i < NV; i++) complete(i, 1'b1, i < NV - 1 ? i + 1 : -1);

        // Backpressure: result held 10 cycles while another tuple is offered.
        @(negedge clk);
        accept(0);
        complete(0, 1'b0, 2);
        held = output_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("stall_valid[%0d]", c), output_valid, 1);
            chk($sformatf("stall_data[%0d]", c), output_data, held);
            chk($sformatf("stall_no_accept[%0d]", c), input_ready, 0);
        end
`ifdef HT_CMP_STATS_EN
        chk("stall_stat_hits", stat_hits, exp_hits);
`endif
        output_ready = 1'b1;
        @(negedge clk);
        chk("release_clear", output_valid, 0);
        chk("release_accept", input_ready, 1);
`ifdef HT_CMP_STATS_EN
        exp_hits++;
        chk("release_stat_hits", stat_hits, exp_hits);
`endif
        complete(2, 1'b1, -1);
`ifdef HT_CMP_STATS_EN
        chk("stat_hits", stat_hits, exp_hits);
        chk("stat_misses", stat_misses, exp_misses);
`endif

        // Reset while waiting for bucket 2, then a fresh tuple.
        @(negedge clk);
        accept(1);
        rddata_data  = mk_word(vecs[1].o1, vecs[1].k1, vecs[1].v1);
        rddata_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        @(negedge clk);
        rddata_data = mk_word(vecs[1].o2, vecs[1].k2, vecs[1].v2);
        chk("pre_rst_rdready", rddata_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        rddata_valid = 1'b0;
`ifdef HT_CMP_STATS_EN
        chk("midrst_stat_hits", stat_hits, 0);
        chk("midrst_stat_misses", stat_misses, 0);
        exp_hits = 0;
        exp_misses = 0;
`endif
        @(negedge clk);
        accept(3);
        complete(3, 1'b1, -1);
`ifdef HT_CMP_STATS_EN
        chk("final_stat_hits", stat_hits, exp_hits);
        chk("final_stat_misses", stat_misses, exp_misses);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
